// File: rtl/decode_issue_queue.sv
// In-order decode/issue instruction buffer: circular queue between fetch and issue
// with age-based selective squash of younger entries.
module decode_issue_queue #(
   parameter int p_seq_num_bits = 5,
   parameter int p_depth        = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            f_val,
   output logic                            f_rdy,
   input  logic [31:0]                     f_inst,
   input  logic [31:0]                     f_pc,
   input  logic [p_seq_num_bits-1:0]       f_seq_num,
   output logic                            d_val,
   input  logic                            d_rdy,
   output logic [31:0]                     d_inst,
   output logic [31:0]                     d_pc,
   output logic [p_seq_num_bits-1:0]       d_seq_num,
   input  logic                            stall,
   input  logic                            squash_val,
   input  logic [p_seq_num_bits-1:0]       squash_seq_num,
   output logic [$clog2(p_depth+1)-1:0]    count
);

   localparam int c_cnt_bits = $clog2(p_depth + 1);
   localparam int c_ptr_bits = $clog2(p_depth);

   logic [31:0]               inst_q [p_depth];
   logic [31:0]               pc_q   [p_depth];
   logic [p_seq_num_bits-1:0] seq_q  [p_depth];

   logic [c_ptr_bits-1:0] head_q, head_d, tail_q, tail_d, wr_ptr;
   logic [c_cnt_bits-1:0] count_q, count_d, survivors;
   logic                  killed_found, head_killed, f_xfer, d_xfer, kept_enq;

   // Wrap-around age test: a is younger than r when (a - r) mod 2^n lies in the
   // lower half of the sequence space, excluding zero.
   function automatic logic younger(input logic [p_seq_num_bits-1:0] a,
                                    input logic [p_seq_num_bits-1:0] r);
      logic [p_seq_num_bits-1:0] diff;
      diff = a - r;
      return (diff != '0) && !diff[p_seq_num_bits-1];
   endfunction

   // Modulo-p_depth pointer advance; p_depth need not be a power of two.
   function automatic logic [c_ptr_bits-1:0] ptr_add(input logic [c_ptr_bits-1:0] p,
                                                     input logic [c_cnt_bits-1:0] n);
      int s;
      s = int'(p) + int'(n);
      if (s >= p_depth) s = s - p_depth;
      return c_ptr_bits'(s);
   endfunction

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      survivors    = count_q;
      killed_found = 1'b0;
      for (int k = 0; k < p_depth; k++) begin
         if (squash_val && !killed_found && (k < int'(count_q)) &&
             younger(seq_q[ptr_add(head_q, c_cnt_bits'(k))], squash_seq_num)) begin
            survivors    = c_cnt_bits'(k);
            killed_found = 1'b1;
         end
      end
   end

   always_comb begin
      f_rdy       = (count_q != c_cnt_bits'(p_depth));
      head_killed = squash_val && (count_q != '0) && younger(seq_q[head_q], squash_seq_num);
      d_val       = (count_q != '0) && !stall && !head_killed;
      f_xfer      = f_val && f_rdy;
      d_xfer      = d_val && d_rdy;
      kept_enq    = f_xfer && !(squash_val && younger(f_seq_num, squash_seq_num));
      // The killed set is a contiguous suffix, so the tail pulls back to head + survivors.
      wr_ptr      = squash_val ? ptr_add(head_q, survivors) : tail_q;
      tail_d      = kept_enq ? ptr_add(wr_ptr, c_cnt_bits'(1)) : wr_ptr;
      head_d      = d_xfer ? ptr_add(head_q, c_cnt_bits'(1)) : head_q;
      count_d     = survivors - c_cnt_bits'(d_xfer) + c_cnt_bits'(kept_enq);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: payload storage is deliberately not reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (!rst && kept_enq) begin
         inst_q[wr_ptr] <= f_inst;
         pc_q[wr_ptr]   <= f_pc;
         seq_q[wr_ptr]  <= f_seq_num;
      end
   end

   assign d_inst    = inst_q[head_q];
   assign d_pc      = pc_q[head_q];
   assign d_seq_num = seq_q[head_q];
   assign count     = count_q;

   a_count_bound : assert property (@(posedge clk) disable iff (rst)
      count_q <= c_cnt_bits'(p_depth));
   a_no_deq_empty : assert property (@(posedge clk) disable iff (rst)
      d_xfer |-> (count_q != '0));

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_decode_issue_queue;

   localparam int SB    = 5;
   localparam int DEPTH = 4;
   localparam int CB    = $clog2(DEPTH + 1);

   logic          clk, rst, f_val, f_rdy, d_val, d_rdy, stall, squash_val;
   logic [31:0]   f_inst, f_pc, d_inst, d_pc;
   logic [SB-1:0] f_seq_num, d_seq_num, squash_seq_num, next_seq;
   logic [CB-1:0] count;

   typedef struct {
      logic [31:0]   inst;
      logic [31:0]   pc;
      logic [SB-1:0] seq;
   } ent_t;

   ent_t q[$];
   bit   last_fx;
   int   n_checks, n_fail;

   decode_issue_queue #(.p_seq_num_bits(SB), .p_depth(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .f_val(f_val), .f_rdy(f_rdy), .f_inst(f_inst), .f_pc(f_pc), .f_seq_num(f_seq_num),
      .d_val(d_val), .d_rdy(d_rdy), .d_inst(d_inst), .d_pc(d_pc), .d_seq_num(d_seq_num),
      .stall(stall), .squash_val(squash_val), .squash_seq_num(squash_seq_num),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit younger(input logic [SB-1:0] a, input logic [SB-1:0] r);
      int d;
      d = (int'(a) - int'(r) + 2**SB) % (2**SB);
      return (d >= 1) && (d <= 2**(SB-1) - 1);
   endfunction

   // Compare outputs against the model, then advance the model across the edge.
   task automatic tick();
      bit   exp_frdy, hk, exp_dval, fx, dx;
      ent_t e;
      ent_t keep[$];
      #1;
      if (rst) begin
         q.delete();
         last_fx = 1'b0;
      end else begin
         exp_frdy = q.size() < DEPTH;
         hk       = squash_val && (q.size() > 0) && younger(q[0].seq, squash_seq_num);
         exp_dval = (q.size() > 0) && !stall && !hk;
         check("count", 64'(count), 64'(q.size()));
         check("f_rdy", 64'(f_rdy), 64'(exp_frdy));
         check("d_val", 64'(d_val), 64'(exp_dval));
         if (exp_dval) begin
            check("d_seq_num", 64'(d_seq_num), 64'(q[0].seq));
            check("d_pc", 64'(d_pc), 64'(q[0].pc));
            check("d_inst", 64'(d_inst), 64'(q[0].inst));
         end
         fx = f_val && exp_frdy;
         dx = exp_dval && d_rdy;
         if (squash_val) begin
            foreach (q[i]) if (!younger(q[i].seq, squash_seq_num)) keep.push_back(q[i]);
            q = keep;
         end
         if (dx) void'(q.pop_front());
         if (fx && !(squash_val && younger(f_seq_num, squash_seq_num))) begin
            e.inst = f_inst;
            e.pc   = f_pc;
            e.seq  = f_seq_num;
            q.push_back(e);
         end
         last_fx = fx;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      f_val = 0; d_rdy = 0; stall = 0; squash_val = 0;
      f_inst = '0; f_pc = '0; f_seq_num = '0; squash_seq_num = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic enq(input logic [SB-1:0] s);
      f_val = 1; f_seq_num = s; f_pc = 32'h200 + 32'(s) * 4; f_inst = $urandom;
      tick();
      f_val = 0;
   endtask

   task automatic squash(input logic [SB-1:0] s);
      squash_val = 1; squash_seq_num = s;
      tick();
      squash_val = 0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; next_seq = '0;
      do_reset();
      check("reset_count", 64'(count), 64'd0);
      check("reset_f_rdy", 64'(f_rdy), 64'd1);
      check("reset_d_val", 64'(d_val), 64'd0);

      // Fill 0..3 without draining, then drain in order.
      for (int s = 0; s < 4; s++) enq(SB'(s));
      check("fill_count", 64'(count), 64'd4);
      check("fill_f_rdy", 64'(f_rdy), 64'd0);
      check("fill_d_val", 64'(d_val), 64'd1);
      check("fill_pc", 64'(d_pc), 64'h200);
      d_rdy = 1;
      for (int s = 0; s < 4; s++) begin
         check("drain_seq", 64'(d_seq_num), 64'(s));
         tick();
      end
      d_rdy = 0;
      check("drain_count", 64'(count), 64'd0);

      // Squash at 6 keeps 5,6; refetched 7 lands after 6.
      do_reset();
      for (int s = 5; s < 9; s++) enq(SB'(s));
      squash(SB'(6));
      check("sq6_count", 64'(count), 64'd2);
      check("sq6_head", 64'(d_seq_num), 64'd5);
      enq(SB'(7));
      d_rdy = 1;
      for (int s = 5; s < 8; s++) begin
         check("sq6_order", 64'(d_seq_num), 64'(s));
         tick();
      end
      d_rdy = 0;

      // Wrap-around ages.
      do_reset();
      enq(SB'(30)); enq(SB'(31)); enq(SB'(0)); enq(SB'(1));
      squash(SB'(31));
      check("wrap31_count", 64'(count), 64'd2);
      squash(SB'(29));
      check("wrap29_count", 64'(count), 64'd0);

      // Head killed while issuing, incoming younger fetch dropped.
      do_reset();
      enq(SB'(3));
      d_rdy = 1; f_val = 1; f_seq_num = SB'(9); squash_val = 1; squash_seq_num = SB'(2);
      #1 check("kill_d_val", 64'(d_val), 64'd0);
      tick();
      idle();
      check("kill_count", 64'(count), 64'd0);

      // Stall blocks issue only.
      do_reset();
      enq(SB'(10)); enq(SB'(11));
      stall = 1;
      #1 check("stall_d_val", 64'(d_val), 64'd0);
      enq(SB'(12)); enq(SB'(13));
      check("stall_count", 64'(count), 64'd4);
      check("stall_f_rdy", 64'(f_rdy), 64'd0);
      stall = 0;
      #1 check("unstall_d_val", 64'(d_val), 64'd1);
      check("unstall_head", 64'(d_seq_num), 64'd10);

      // Full with dequeue: no enqueue this cycle, accepted next cycle.
      d_rdy = 1; f_val = 1; f_seq_num = SB'(14); f_pc = 32'h238;
      tick();
      check("full_deq_count", 64'(count), 64'd3);
      d_rdy = 0;
      tick();
      f_val = 0;
      check("refill_count", 64'(count), 64'd4);

      // Randomized traffic with squash references kept near the in-flight window.
      do_reset();
      next_seq = SB'(20);
      for (int n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(99) == 0);
         f_val          = $urandom_range(1);
         d_rdy          = $urandom_range(1);
         stall          = ($urandom_range(3) == 0);
         f_seq_num      = next_seq;
         f_pc           = $urandom;
         f_inst         = $urandom;
         squash_val     = ($urandom_range(7) == 0);
         if (q.size() > 0) squash_seq_num = q[0].seq + SB'($urandom_range(8)) - SB'(2);
         else              squash_seq_num = next_seq + SB'($urandom_range(4)) - SB'(3);
         tick();
         if (last_fx) next_seq = next_seq + SB'(1);
      end
      rst = 0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Parametrised-depth, in-order instruction buffer between fetch and the decode/issue datapath.
- Replaces the single fetch pipeline register so that fetch can run ahead of issue stalls.
- Holds up to p_depth fetched instructions in program order and presents the oldest to issue.
- Selectively flushes entries younger than a squash sequence number, using wrap-around age comparison.

Parameters:
p_seq_num_bits, 5, width of instruction sequence numbers
p_depth, 4, number of buffer entries (any integer >= 2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
f_val  input  1  fetch presents an instruction
f_rdy  output  1  queue can accept an instruction this cycle
f_inst  input  32  fetched instruction word
f_pc  input  32  fetched PC
f_seq_num  input  p_seq_num_bits  fetched sequence number
d_val  output  1  head instruction offered to decode/issue
d_rdy  input  1  decode/issue accepts head
d_inst  output  32  head instruction word
d_pc  output  32  head PC
d_seq_num  output  p_seq_num_bits  head sequence number
stall  input  1  issue-side hazard stall (rename full, operand pending)
squash_val  input  1  squash notification valid
squash_seq_num  input  p_seq_num_bits  sequence number of squashing instruction
count  output  $clog2(p_depth+1)  current occupancy

Behaviour:
- Circular buffer with head pointer, tail pointer and occupancy count. Pointers wrap modulo p_depth; p_depth need not be a power of two.
- Reset (synchronous): count=0 and head=tail=0 on the next edge.
  - After reset: d_val=0, f_rdy=1, count=0.
  - Entry payloads are don't-care.
  - Reset mid-operation discards all entries, and any same-cycle enqueue, squash or dequeue is ignored.
- Enqueue:
  - f_xfer = f_val & f_rdy.
  - f_rdy = (count < p_depth). It is registered-state only and has no combinational path from d_rdy.
  - When full, f_rdy=0 even if the head dequeues that cycle.
- Dequeue:
  - d_val = (count != 0) & !stall & !head_killed.
  - d_xfer = d_val & d_rdy.
  - d_inst, d_pc and d_seq_num always reflect the head entry. They are don't-care when count=0.
- Latency:
  - An instruction accepted at edge N is offered at d_val in cycle N+1 at the earliest.
  - There is no same-cycle bypass from f to d.
- Age rule:
  - younger(a, ref) = ((a - ref) mod 2^p_seq_num_bits) is in [1, 2^(p_seq_num_bits-1)-1].
  - Equal sequence numbers are not younger, so the squashing instruction itself survives.
- Squash (squash_val=1):
  - Every stored entry with younger(entry.seq_num, squash_seq_num) is invalidated. Stored entries are in program order, so the killed set is a contiguous suffix. The tail pulls back to the first killed entry and count drops accordingly.
  - head_killed = younger(head.seq_num, squash_seq_num). When set, d_val=0 that cycle.
  - An incoming f_xfer whose f_seq_num is younger is dropped and not written. A non-younger incoming instruction is enqueued normally.
  - A squash that kills nothing leaves state unchanged, apart from any normal enqueue/dequeue.
- Simultaneous events in one cycle:
  - count_next = survivors - d_xfer + kept_enq.
  - The dequeue is always of a surviving head, which the d_val gating guarantees.
  - Enqueue while full is impossible because f_rdy=0.
  - Enqueue and dequeue together at count=p_depth-1 leaves count unchanged.
  - Squash of all entries plus a kept enqueue gives count_next=1 with the new entry at the pulled-back tail.
- stall only gates d_val. It never blocks enqueue or squash.
- Assertions (simulation only):
  - count never exceeds p_depth.
  - No d_xfer when count=0.

Test Plan:
- Reset, then enqueue seq 0..3 (pc 0x200, 0x204, 0x208, 0x20C) with d_rdy=0 -> count=4, f_rdy=0, d_val=1, d_seq_num=0. Then d_rdy=1 for 4 cycles -> seq 0, 1, 2, 3 dequeued in order, count returns to 0, f_rdy=1 from the first dequeue edge onward.
- Queue holds seq 5, 6, 7, 8; squash_val=1, squash_seq_num=6 -> next cycle count=2, head seq 5; next enqueue seq 7 lands after 6.
- Wrap-around: p_seq_num_bits=5, queue holds 30, 31, 0, 1; squash_seq_num=31 -> entries 0 and 1 killed, count=2; squash_seq_num=29 -> all killed except none older, count=0.
- Same cycle: head seq 3 issuing (d_rdy=1), f_val with seq 9, squash_seq_num=2 -> d_val=0 (head killed), seq 9 dropped, count_next=0.
- stall=1 with count=2 -> d_val=0 and count stays 2. Enqueue continues to count=4, then f_rdy=0. Release stall -> d_val=1 with the head unchanged.
- Full queue with d_rdy=1 and f_val=1 -> f_rdy=0, so no enqueue; count 4->3; the next cycle accepts.
